// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if
//   Bundles the retire-side handshakes, the issue hint and the RegisterFile
//   write port of regfile_writeback.
//
//   Handshake rule (alu_* and mem_*): a result transfers on a rising edge
//   where valid and ready are both 1. The producer holds valid, rd and data
//   stable until that edge. ready never depends on valid from the same port.
//
//   Modports:
//     master - producer / environment side: drives results and issue hints,
//              observes ready, the write port, pending_mask and fifo_count
//     slave  - regfile_writeback itself
interface regfile_writeback_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              mem_ready;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;

    logic              register_wr;
    logic [ADDR_W-1:0] write_register_addr;
    logic [XLEN-1:0]   write_register_data;
    logic [31:0]       pending_mask;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd,
        input  register_wr, write_register_addr, write_register_data,
        input  pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd,
        output register_wr, write_register_addr, write_register_data,
        output pending_mask, fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side driver for the RegisterFile. Accepts retiring ALU and load
//   results, queues them in a DEPTH-entry FIFO and emits at most one
//   registered register write per cycle. Also keeps pending_mask, a
//   per-register "write outstanding" scoreboard for the issue logic.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high; empties the FIFO, clears the
//              write port and pending_mask
//     bus    - regfile_writeback_if.slave: alu_*/mem_* result handshakes,
//              issue_valid/issue_rd, register_wr/write_register_addr/
//              write_register_data, pending_mask, fifo_count
module regfile_writeback #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_writeback_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_rd   [DEPTH];
    logic [XLEN-1:0]   fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] push_rd;
    logic [XLEN-1:0]   push_data;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   data_q;
    logic [31:0]       pend_q, pend_d;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Loads have fixed priority; ready ignores a same-cycle pop so a full
    // FIFO never passes a result straight through.
    assign bus.mem_ready = !full;
    assign bus.alu_ready = !full && !bus.mem_valid;

    // Select the single accepted result. rd==0 still handshakes but is
    // dropped here, since x0 is never written.
    always_comb begin
        push      = 1'b0;
        push_rd   = bus.mem_rd;
        push_data = bus.mem_data;
        if (bus.mem_valid && !full) begin
            push = (bus.mem_rd != '0);
        end else if (bus.alu_valid && !full) begin
            push      = (bus.alu_rd != '0);
            push_rd   = bus.alu_rd;
            push_data = bus.alu_data;
        end
    end

    assign pop = !empty;

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= push_rd;
            fifo_data[wr_ptr] <= push_data;
        end
    end

    // Clear on the edge that ends a register_wr cycle (the RegisterFile
    // commit edge); a same-edge issue to the same register re-sets the bit.
    always_comb begin
        pend_d = pend_q;
        if (wr_q) begin
            pend_d[addr_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= fifo_rd[rd_ptr];
                data_q <= fifo_data[rd_ptr];
            end
            wr_q <= pop;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            pend_q <= pend_d;
        end
    end

    assign bus.register_wr         = wr_q;
    assign bus.write_register_addr = addr_q;
    assign bus.write_register_data = data_q;
    assign bus.pending_mask        = pend_q;
    assign bus.fifo_count          = count;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int W      = ADDR_W + XLEN;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_writeback #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the buffered writes as a queue of {rd,data}, the
    // current write-port contents and the set of outstanding registers.
    logic [W-1:0]      mq[$];
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [XLEN-1:0]   m_data;
    logic [31:0]       m_pend;

    // Scoreboard of writes expected on the RegisterFile port, in order.
    logic [W-1:0]      exp_q[$];

    task automatic model_clear();
        mq.delete();
        m_wr = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
    endtask

    // Advance one clock, updating the model from the rules of the block.
    task automatic tick();
        logic              acc;
        logic [W-1:0]      ne, e;
        logic              o_wr;
        logic [ADDR_W-1:0] o_addr;
        bit                is_full;
        is_full = (mq.size() >= DEPTH);
        acc = 1'b0;
        ne = '0;
        if (bus.mem_valid && !is_full) begin
            acc = (bus.mem_rd != 0);
            ne  = {bus.mem_rd, bus.mem_data};
        end else if (bus.alu_valid && !bus.mem_valid && !is_full) begin
            acc = (bus.alu_rd != 0);
            ne  = {bus.alu_rd, bus.alu_data};
        end
        o_wr = m_wr;
        o_addr = m_addr;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_wr = 1'b1;
            m_addr = e[W-1:XLEN];
            m_data = e[XLEN-1:0];
        end else begin
            m_wr = 1'b0;
        end
        if (acc) mq.push_back(ne);
        if (o_wr) m_pend[o_addr] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
        m_pend[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%0b exp=0", bus.register_wr); end
        checks++; if (bus.write_register_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.write_register_addr); end
        checks++; if (bus.write_register_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.write_register_data); end
        checks++; if (bus.pending_mask !== '0) begin failures++; $display("FAIL reset_pend got=%0h exp=0", bus.pending_mask); end
        checks++; if (bus.fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
        reset = 1'b0;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL first_alu_ready got=%0b exp=1", bus.alu_ready); end
        tick();  // accept edge
        bus.alu_valid = 1'b0;
        checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL lat_edge1_wr got=%0b exp=0", bus.register_wr); end
        checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL lat_edge1_count got=%0d exp=1", bus.fifo_count); end
        tick();
        checks++; if (bus.register_wr !== 1'b1) begin failures++; $display("FAIL lat_edge2_wr got=%0b exp=1", bus.register_wr); end
        checks++; if (bus.write_register_addr !== 5'd5) begin failures++; $display("FAIL lat_edge2_addr got=%0d exp=5", bus.write_register_addr); end
        checks++; if (bus.write_register_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lat_edge2_data got=%0h exp=deadbeef", bus.write_register_data); end
        tick();
        checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL lat_edge3_wr got=%0b exp=0", bus.register_wr); end
    endtask

    task automatic test_priority();
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h3333_0003;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h4444_0004;
        #1;
        checks++; if (bus.alu_ready !== 1'b0) begin failures++; $display("FAIL prio_alu_ready got=%0b exp=0", bus.alu_ready); end
        checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL prio_mem_ready got=%0b exp=1", bus.mem_ready); end
        tick();
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL prio_alu_ready2 got=%0b exp=1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if ({bus.register_wr, bus.write_register_addr} !== {1'b1, 5'd3}) begin failures++; $display("FAIL prio_first got=%0b/%0d exp=1/3", bus.register_wr, bus.write_register_addr); end
        checks++; if (bus.write_register_data !== 32'h3333_0003) begin failures++; $display("FAIL prio_first_data got=%0h exp=33330003", bus.write_register_data); end
        tick();
        checks++; if ({bus.register_wr, bus.write_register_addr} !== {1'b1, 5'd4}) begin failures++; $display("FAIL prio_second got=%0b/%0d exp=1/4", bus.register_wr, bus.write_register_addr); end
        checks++; if (bus.write_register_data !== 32'h4444_0004) begin failures++; $display("FAIL prio_second_data got=%0h exp=44440004", bus.write_register_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_w;
        idle_inputs();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd = ADDR_W'($urandom_range(1, 31));
                bus.alu_data = $urandom;
                exp_q.push_back({bus.alu_rd, bus.alu_data});
            end else begin
                bus.alu_valid = 1'b0;
            end
            tick();
            checks++; if (bus.fifo_count > 3'(DEPTH)) begin failures++; $display("FAIL b2b_count_max cyc=%0d got=%0d exp<=%0d", i, bus.fifo_count, DEPTH); end
            if (i >= 1 && i < 10) begin
                checks++; if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count_const cyc=%0d got=%0d exp=1", i, bus.fifo_count); end
            end
            if (i >= 1 && i <= 10) begin
                checks++;
                if (bus.register_wr !== 1'b1 || exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_wr cyc=%0d got=%0b exp=1", i, bus.register_wr);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus.write_register_addr, bus.write_register_data} !== exp_w) begin
                        failures++; $display("FAIL b2b_write cyc=%0d got=%0h exp=%0h", i, {bus.write_register_addr, bus.write_register_data}, exp_w);
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0 || bus.register_wr !== 1'b0) begin failures++; $display("FAIL b2b_drain left=%0d wr=%0b exp=0/0", exp_q.size(), bus.register_wr); end
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_rd = '0; bus.alu_data = 32'h1;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%0b exp=1", bus.alu_ready); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.fifo_count !== '0) begin failures++; $display("FAIL rd0_count got=%0d exp=0", bus.fifo_count); end
        tick();
        checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL rd0_wr got=%0b exp=0", bus.register_wr); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        checks++; if (bus.pending_mask[7] !== 1'b1) begin failures++; $display("FAIL sb_set got=%0b exp=1", bus.pending_mask[7]); end
        tick(); tick();
        checks++; if (bus.pending_mask[7] !== 1'b1) begin failures++; $display("FAIL sb_hold got=%0b exp=1", bus.pending_mask[7]); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        checks++; if ({bus.register_wr, bus.pending_mask[7]} !== 2'b11) begin failures++; $display("FAIL sb_wr_cycle got=%0b exp=11", {bus.register_wr, bus.pending_mask[7]}); end
        tick();
        checks++; if (bus.pending_mask[7] !== 1'b0) begin failures++; $display("FAIL sb_clear got=%0b exp=0", bus.pending_mask[7]); end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7778;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;  // reissue on the commit edge
        tick();
        bus.issue_valid = 1'b1; bus.issue_rd = '0;
        checks++; if (bus.pending_mask[7] !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%0b exp=1", bus.pending_mask[7]); end
        tick();
        bus.issue_valid = 1'b0;
        checks++; if (bus.pending_mask[0] !== 1'b0) begin failures++; $display("FAIL sb_x0 got=%0b exp=0", bus.pending_mask[0]); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h9999;
        tick();
        bus.issue_valid = 1'b0;
        bus.alu_rd = 5'd10; bus.alu_data = 32'hAAAA;
        tick();
        checks++; if ({bus.register_wr, bus.pending_mask[9]} !== 2'b11) begin failures++; $display("FAIL mid_pre got=%0b exp=11", {bus.register_wr, bus.pending_mask[9]}); end
        #2 reset = 1'b1;
        #1;
        model_clear();
        checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL mid_async_wr got=%0b exp=0", bus.register_wr); end
        checks++; if (bus.pending_mask !== '0) begin failures++; $display("FAIL mid_pend got=%0h exp=0", bus.pending_mask); end
        checks++; if (bus.fifo_count !== '0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.fifo_count); end
        bus.alu_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.register_wr !== 1'b0) begin failures++; $display("FAIL mid_no_write cyc=%0d got=%0b exp=0", i, bus.register_wr); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.mem_valid = ($urandom_range(0, 9) < 3);
            bus.mem_rd = ADDR_W'($urandom_range(0, 31));
            bus.mem_data = $urandom;
            bus.alu_valid = ($urandom_range(0, 9) < 6);
            bus.alu_rd = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
            bus.alu_data = $urandom;
            bus.issue_valid = ($urandom_range(0, 3) == 0);
            bus.issue_rd = ADDR_W'($urandom_range(0, 31));
            #1;
            checks++; if (bus.mem_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_mem_ready cyc=%0d got=%0b", i, bus.mem_ready); end
            checks++; if (bus.alu_ready !== (mq.size() < DEPTH && !bus.mem_valid)) begin failures++; $display("FAIL rnd_alu_ready cyc=%0d got=%0b", i, bus.alu_ready); end
            tick();
            checks++; if (bus.register_wr !== m_wr) begin failures++; $display("FAIL rnd_wr cyc=%0d got=%0b exp=%0b", i, bus.register_wr, m_wr); end
            checks++; if (bus.write_register_addr !== m_addr || bus.write_register_data !== m_data) begin failures++; $display("FAIL rnd_write cyc=%0d got=%0d/%0h exp=%0d/%0h", i, bus.write_register_addr, bus.write_register_data, m_addr, m_data); end
            checks++; if (bus.pending_mask !== m_pend) begin failures++; $display("FAIL rnd_pend cyc=%0d got=%0h exp=%0h", i, bus.pending_mask, m_pend); end
            checks++; if (int'(bus.fifo_count) != mq.size()) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, bus.fifo_count, mq.size()); end
        end
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_priority();
        test_back_to_back();
        test_rd_zero();
        test_scoreboard();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
